// File: rtl/mem_resp_ram.sv
// rtl/mem_resp_ram.sv - word-addressed memory responder with first/next wait states
module mem_resp_ram #(
   parameter int ADDR_WIDTH       = 10,
   parameter int LINE_WORDS_WIDTH = 2,
   parameter int FIRST_LATENCY    = 4,
   parameter int NEXT_LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_cs_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        mem_ack_o
);

   localparam int         DEPTH     = 1 << ADDR_WIDTH;
   // Counter load values: the ack-raising edge is the one that finds the counter at zero.
   localparam logic [3:0] FIRST_CNT = 4'(FIRST_LATENCY - 1);
   localparam logic [3:0] NEXT_CNT  = 4'(NEXT_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:2] addr_q, addr_d;
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] data_q, data_d;
   logic        ack_q, ack_d;
   logic        burst_q, burst_d;

   logic [31:0]           mem [DEPTH];
   logic                  mem_wr_en;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  burst_hit;
   logic                  unused_addr_bits;

   // Upper address bits alias for indexing but still take part in the line match.
   assign idx              = addr_q[ADDR_WIDTH+1:2];
   assign burst_hit        = (state_q == S_ACK)
                             && (mem_addr_i[31:LINE_WORDS_WIDTH+2] == addr_q[31:LINE_WORDS_WIDTH+2])
                             && (mem_we_i == we_q);
   assign unused_addr_bits = ^mem_addr_i[1:0];

   // Next-state, request capture, latency countdown and access decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      data_d    = data_q;
      ack_d     = 1'b0;
      burst_d   = burst_q;
      mem_wr_en = 1'b0;
      case (state_q)
         S_IDLE, S_ACK: begin
            if (mem_cs_i) begin
               addr_d  = mem_addr_i[31:2];
               we_d    = mem_we_i;
               wdata_d = mem_data_i;
               burst_d = burst_hit;
               cnt_d   = burst_hit ? NEXT_CNT : FIRST_CNT;
               state_d = S_WAIT;
            end else begin
               burst_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (!mem_cs_i) begin
               burst_d = 1'b0;
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               ack_d   = 1'b1;
               state_d = S_ACK;
               if (we_q) begin
                  mem_wr_en = !rst;
               end else begin
                  data_d = mem[idx];
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            burst_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and output registers; reset abandons any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= 32'd0;
         data_q  <= 32'd0;
         ack_q   <= 1'b0;
         burst_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         burst_q <= burst_d;
      end
   end

   // Word array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_wr_en) begin
         mem[idx] <= wdata_q;
      end
   end

   assign mem_data_o = data_q;
   assign mem_ack_o  = ack_q;

endmodule

// File: tb/tb_mem_resp_ram.sv
// tb/tb_mem_resp_ram.sv - self-checking bench for mem_resp_ram
module tb_mem_resp_ram;

   localparam int FL = 4;
   localparam int NL = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_cs_i = 1'b0;
   logic        mem_we_i = 1'b0;
   logic [31:0] mem_addr_i = 32'd0;
   logic [31:0] mem_data_i = 32'd0;
   logic [31:0] mem_data_o;
   logic        mem_ack_o;

   int total = 0;
   int bad = 0;

   mem_resp_ram #(
      .ADDR_WIDTH(10),
      .LINE_WORDS_WIDTH(2),
      .FIRST_LATENCY(FL),
      .NEXT_LATENCY(NL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mem_cs_i(mem_cs_i),
      .mem_we_i(mem_we_i),
      .mem_addr_i(mem_addr_i),
      .mem_data_i(mem_data_i),
      .mem_data_o(mem_data_o),
      .mem_ack_o(mem_ack_o)
   );

   always #5 clk = ~clk;

   // Transaction-level model: each sampled request is due a fixed number of edges later.
   int          cyc = 0;
   bit          pend = 0;
   int          due = 0;
   logic [31:0] p_addr = 0, p_wd = 0;
   logic        p_we = 0;
   int          last_ack = -100;
   logic [31:0] l_addr = 0;
   logic        l_we = 0;
   logic        exp_ack = 0;
   logic [31:0] exp_data = 0;
   logic [31:0] mmem [1024];

   initial begin
      for (int i = 0; i < 1024; i++) mmem[i] = 32'd0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            pend = 0;
            exp_ack = 0;
            exp_data = 0;
            last_ack = -100;
         end else begin
            cyc = cyc + 1;
            exp_ack = 0;
            if (pend) begin
               if (!mem_cs_i) begin
                  pend = 0;
               end else if (cyc == due) begin
                  if (p_we) mmem[p_addr[11:2]] = p_wd;
                  else exp_data = mmem[p_addr[11:2]];
                  exp_ack = 1;
                  last_ack = cyc;
                  l_addr = p_addr;
                  l_we = p_we;
                  pend = 0;
               end
            end else if (mem_cs_i) begin
               p_addr = mem_addr_i;
               p_we = mem_we_i;
               p_wd = mem_data_i;
               if (last_ack == cyc - 1 && mem_addr_i[31:4] == l_addr[31:4] && mem_we_i == l_we)
                  due = cyc + NL;
               else
                  due = cyc + FL;
               pend = 1;
            end
         end
      end
   end

   // Every-cycle comparison of the DUT outputs against the model.
   always @(negedge clk) begin
      total = total + 1;
      if (mem_ack_o !== exp_ack || mem_data_o !== exp_data) begin
         bad = bad + 1;
         $display("FAIL cycle_check cyc=%0d ack got %b want %b, data got %h want %h",
                  cyc, mem_ack_o, exp_ack, mem_data_o, exp_data);
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total = total + 1;
      if (act !== expv) begin
         bad = bad + 1;
         $display("FAIL %s: got %h want %h", nm, act, expv);
      end
   endtask

   // Issue one request from a negedge; returns in the ack cycle (at its negedge).
   task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input bit keep, output int lat, output logic [31:0] rd, output int ac);
      int s;
      mem_cs_i = 1'b1;
      mem_we_i = w;
      mem_addr_i = a;
      mem_data_i = d;
      @(posedge clk);
      #1 s = cyc;
      lat = -1;
      ac = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_ack_o) begin
            lat = cyc - s;
            ac = cyc;
            break;
         end
      end
      if (lat < 0) begin
         total = total + 1;
         bad = bad + 1;
         $display("FAIL ack_timeout addr %h got no ack want ack", a);
      end
      rd = mem_data_o;
      if (!keep) begin
         mem_cs_i = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      int lat, ac, s0;
      logic [31:0] rd;
      logic [31:0] ldat [4];
      ldat[0] = 32'h1111_0100;
      ldat[1] = 32'h1111_0104;
      ldat[2] = 32'h1111_0108;
      ldat[3] = 32'h1111_010C;

      repeat (3) @(negedge clk);
      check("reset_ack", {31'd0, mem_ack_o}, 32'd0);
      check("reset_data", mem_data_o, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      access(32'h40, 1'b1, 32'hDEADBEEF, 1'b0, lat, rd, ac);
      check("wr40_lat", lat, 32'd4);
      access(32'h40, 1'b0, 32'h0, 1'b0, lat, rd, ac);
      check("rd40_lat", lat, 32'd4);
      check("rd40_data", rd, 32'hDEADBEEF);

      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("idle_rst_data", mem_data_o, 32'd0);

      access(32'h10, 1'b1, 32'hAAAA_0010, 1'b0, lat, rd, ac);
      mem_cs_i = 1'b1;
      mem_we_i = 1'b1;
      mem_addr_i = 32'h10;
      mem_data_i = 32'hBBBB_BBBB;
      @(posedge clk);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      mem_cs_i = 1'b0;
      @(negedge clk);
      access(32'h10, 1'b0, 32'h0, 1'b0, lat, rd, ac);
      check("rst_wait_lat", lat, 32'd4);
      check("rst_wait_data", rd, 32'hAAAA_0010);

      for (int i = 0; i < 4; i++) begin
         access(32'h100 + 32'(4 * i), 1'b1, ldat[i], i < 3, lat, rd, ac);
         check("burst_wr_lat", lat, (i == 0) ? 32'd4 : 32'd1);
      end
      access(32'h110, 1'b1, 32'h2222_0110, 1'b0, lat, rd, ac);

      for (int i = 0; i < 4; i++) begin
         access(32'h100 + 32'(4 * i), 1'b0, 32'h0, i < 3, lat, rd, ac);
         if (i == 0) s0 = ac - lat;
         check("burst_rd_offset", ac - s0, 32'(4 + 2 * i));
         check("burst_rd_data", rd, ldat[i]);
      end

      access(32'h10C, 1'b0, 32'h0, 1'b1, lat, rd, ac);
      access(32'h110, 1'b0, 32'h0, 1'b0, lat, rd, ac);
      check("cross_line_lat", lat, 32'd4);
      check("cross_line_data", rd, 32'h2222_0110);
      access(32'h100, 1'b0, 32'h0, 1'b1, lat, rd, ac);
      access(32'h104, 1'b1, 32'h3333_0104, 1'b0, lat, rd, ac);
      check("rd_then_wr_lat", lat, 32'd4);
      access(32'h104, 1'b0, 32'h0, 1'b0, lat, rd, ac);
      check("raw_data", rd, 32'h3333_0104);

      access(32'h80, 1'b1, 32'h8080_8080, 1'b0, lat, rd, ac);
      mem_cs_i = 1'b1;
      mem_we_i = 1'b1;
      mem_addr_i = 32'h80;
      mem_data_i = 32'h5555_5555;
      @(posedge clk);
      repeat (2) @(negedge clk);
      mem_cs_i = 1'b0;
      @(negedge clk);
      access(32'h80, 1'b0, 32'h0, 1'b0, lat, rd, ac);
      check("abort_next_lat", lat, 32'd4);
      check("abort_data", rd, 32'h8080_8080);

      access(32'h1003, 1'b1, 32'h1234_5678, 1'b0, lat, rd, ac);
      access(32'h0, 1'b0, 32'h0, 1'b0, lat, rd, ac);
      check("alias_data", rd, 32'h1234_5678);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
